// File: rtl/cpu_types_pkg.sv
// Core-wide datapath types shared by the CPU, caches and memory_control.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/icache_pkg.sv
// Instruction cache types: fetch address split, frame layout and fill state.
// The cache top is parameterised; these types are sized for the default geometry.
package icache_pkg;
  import cpu_types_pkg::*;

  localparam int SETS_DEF     = 16;
  localparam int BLKWORDS_DEF = 2;
  localparam int IDXW_DEF     = $clog2(SETS_DEF);
  localparam int OFFW_DEF     = $clog2(BLKWORDS_DEF);
  localparam int TAGW_DEF     = 30 - IDXW_DEF - OFFW_DEF;

  typedef struct packed {
    logic [TAGW_DEF-1:0] tag;
    logic [IDXW_DEF-1:0] idx;
    logic [OFFW_DEF-1:0] blkoff;
    logic [1:0]          bytoff;
  } icachef_t;

  typedef struct packed {
    logic                           valid;
    logic [TAGW_DEF-1:0]            tag;
    word_t [BLKWORDS_DEF-1:0]       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;
endpackage

// File: rtl/icache_fill_fsm.sv
// Miss handler for icache_ctrl: latches the missing block, walks its words through
// memory_control and hands each accepted word to the frame array.
module icache_fill_fsm
  import icache_pkg::*;
#(
  parameter int TAGW     = 25,
  parameter int IDXW     = 4,
  parameter int OFFW     = 1,
  parameter int CNTW     = 1,
  parameter int BLKWORDS = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            miss,
  input  logic [TAGW-1:0] req_tag,
  input  logic [IDXW-1:0] req_idx,
  input  logic            iwait,
  output logic            idle,
  output logic            iREN,
  output logic [31:0]     iaddr,
  output logic            wr_en,
  output logic            fill_done,
  output logic [TAGW-1:0] wr_tag,
  output logic [IDXW-1:0] wr_idx,
  output logic [CNTW-1:0] wr_off
);

  icache_state_t   state_q, state_d;
  logic [TAGW-1:0] miss_tag_q, miss_tag_d;
  logic [IDXW-1:0] miss_idx_q, miss_idx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            last;
  logic [31:0]     fill_addr;

  // A single-word block has no counter; every accepted word is the last one.
  assign last = (OFFW == 0) ? 1'b1 : (cnt_q == CNTW'(BLKWORDS - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    cnt_d      = cnt_q;
    iREN       = 1'b0;
    wr_en      = 1'b0;
    fill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          state_d    = FILL;
          miss_tag_d = req_tag;
          miss_idx_d = req_idx;
          cnt_d      = '0;
        end
      end
      FILL: begin
        iREN = 1'b1;
        if (!iwait) begin
          wr_en = 1'b1;
          cnt_d = last ? '0 : cnt_q + CNTW'(1);
          if (last) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  generate
    if (OFFW == 0) begin : g_word_blk
      assign fill_addr = {miss_tag_q, miss_idx_q, 2'b00};
    end else begin : g_multi_blk
      assign fill_addr = {miss_tag_q, miss_idx_q, cnt_q, 2'b00};
    end
  endgenerate

  assign iaddr  = iREN ? fill_addr : '0;
  assign idle   = (state_q == IDLE);
  assign wr_tag = miss_tag_q;
  assign wr_idx = miss_idx_q;
  assign wr_off = cnt_q;

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache; hits are served combinationally.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_ctrl
  import cpu_types_pkg::*;
  import icache_pkg::*;
#(
  parameter int SETS     = SETS_DEF,
  parameter int BLKWORDS = BLKWORDS_DEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output word_t       imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  word_t       iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDXW = $clog2(SETS);
  localparam int OFFW = $clog2(BLKWORDS);
  localparam int TAGW = 30 - IDXW - OFFW;
  localparam int CNTW = (OFFW == 0) ? 1 : OFFW;

  logic [TAGW-1:0] req_tag;
  logic [IDXW-1:0] req_idx;
  logic [CNTW-1:0] req_off;
  logic            unused_bytoff;

  logic            fill_idle, fill_wr_en, fill_done;
  logic [TAGW-1:0] fill_tag;
  logic [IDXW-1:0] fill_idx;
  logic [CNTW-1:0] fill_off;
  logic            hit, miss;

  logic [SETS-1:0] valid_q, valid_d;
  logic [TAGW-1:0] tag_q  [SETS];
  logic [TAGW-1:0] tag_d  [SETS];
  word_t           data_q [SETS][BLKWORDS];
  word_t           data_d [SETS][BLKWORDS];

  assign req_tag       = imemaddr[31 -: TAGW];
  assign req_idx       = imemaddr[2+OFFW +: IDXW];
  assign unused_bytoff = ^imemaddr[1:0];

  generate
    if (OFFW == 0) begin : g_no_off
      assign req_off = '0;
    end else begin : g_off
      assign req_off = imemaddr[2 +: OFFW];
    end
  endgenerate

  icache_fill_fsm #(
    .TAGW     (TAGW),
    .IDXW     (IDXW),
    .OFFW     (OFFW),
    .CNTW     (CNTW),
    .BLKWORDS (BLKWORDS)
  ) u_fill (
    .CLK       (CLK),
    .nRST      (nRST),
    .miss      (miss),
    .req_tag   (req_tag),
    .req_idx   (req_idx),
    .iwait     (iwait),
    .idle      (fill_idle),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .wr_en     (fill_wr_en),
    .fill_done (fill_done),
    .wr_tag    (fill_tag),
    .wr_idx    (fill_idx),
    .wr_off    (fill_off)
  );

  // Lookups only happen in IDLE; a frame being filled has its valid bit low.
  always_comb begin
    hit      = imemREN & fill_idle & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
    miss     = imemREN & fill_idle & ~hit;
    ihit     = hit;
    imemload = hit ? data_q[req_idx][req_off] : '0;
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (miss) begin
      valid_d[req_idx] = 1'b0;
    end
    if (fill_done) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = fill_tag;
    end
  end

  always_comb begin
    data_d = data_q;
    if (fill_wr_en) begin
      data_d[fill_idx][fill_off] = iload;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

  always_ff @(posedge CLK) begin
    data_q <= data_d;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (miss && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomised bench for icache_ctrl against a block-residency model of the cache.
module tb_icache_ctrl;
  import cpu_types_pkg::*;

  localparam int SETS     = 16;
  localparam int BLKWORDS = 2;
  localparam int OFFW     = $clog2(BLKWORDS);

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  word_t       imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  word_t       iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int          checkCount = 0;
  int          passCount  = 0;
  bit          resValid [SETS];
  logic [31:0] resBlk   [SETS];
  logic [31:0] modelHits   = 0;
  logic [31:0] modelMisses = 0;

  icache_ctrl #(
    .SETS     (SETS),
    .BLKWORDS (BLKWORDS)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Backing memory contents: a fixed scramble of the word address.
  function automatic word_t memWord(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  task automatic checkStats();
`ifdef ICACHE_STATS_EN
    checkOutput("hit_cnt", hit_cnt, modelHits);
    checkOutput("miss_cnt", miss_cnt, modelMisses);
`endif
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyIdle();
    imemREN  = 1'b0;
    imemaddr = $urandom;
    iwait    = 1'b1;
    #4;
    checkStats();
    checkOutput("ihit_idle", 32'(ihit), 32'd0);
    checkOutput("imemload_idle", imemload, 32'd0);
    checkOutput("iREN_idle", 32'(iREN), 32'd0);
    stepCycle();
  endtask

  // One fetch from the IDLE cycle; on a miss, serves the whole fill as memory_control.
  task automatic applyStimulus(input logic [31:0] addr, input int stallMode,
                               input int longStallWord, input bit doRedirect,
                               input logic [31:0] redirAddr);
    logic [31:0] blk, base;
    int          idx, stall;
    bit          expHit;
    imemREN  = 1'b1;
    imemaddr = addr;
    iwait    = 1'b1;
    iload    = '0;
    #4;
    blk    = addr >> (OFFW + 2);
    base   = blk << (OFFW + 2);
    idx    = int'(blk % SETS);
    expHit = resValid[idx] && (resBlk[idx] == blk);
    checkStats();
    checkOutput("ihit_lookup", 32'(ihit), 32'(expHit));
    checkOutput("iREN_lookup", 32'(iREN), 32'd0);
    if (expHit) begin
      checkOutput("imemload_hit", imemload, memWord(addr));
      modelHits++;
      stepCycle();
      return;
    end
    checkOutput("imemload_miss", imemload, 32'd0);
    modelMisses++;
    resValid[idx] = 1'b0;
    for (int w = 0; w < BLKWORDS; w++) begin
      stall = (w == longStallWord) ? 20 :
              (stallMode < 0) ? int'($urandom_range(0, 3)) : stallMode;
      stepCycle();
      if (doRedirect && (w == 1)) begin
        imemaddr = redirAddr;
        imemREN  = 1'($urandom_range(0, 1));
      end
      for (int s = 0; s <= stall; s++) begin
        iwait = (s != stall);
        iload = iwait ? word_t'($urandom) : memWord(base + 32'(4 * w));
        #4;
        checkOutput("iREN_fill", 32'(iREN), 32'd1);
        checkOutput("iaddr_fill", iaddr, base + 32'(4 * w));
        checkOutput("ihit_fill", 32'(ihit), 32'd0);
        if (s != stall) stepCycle();
      end
    end
    resBlk[idx]   = blk;
    resValid[idx] = 1'b1;
    stepCycle();
    iwait = 1'b1;
    iload = '0;
  endtask

  initial begin
    logic [31:0] a, r;
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    for (int i = 0; i < SETS; i++) begin
      resValid[i] = 1'b0;
      resBlk[i]   = '0;
    end
    #2;
    checkOutput("rst_ihit", 32'(ihit), 32'd0);
    checkOutput("rst_iREN", 32'(iREN), 32'd0);
    checkOutput("rst_iaddr", iaddr, 32'd0);
    checkOutput("rst_imemload", imemload, 32'd0);
    checkStats();
    #5;
    nRST = 1'b1;
    stepCycle();

    $display("[TB] cold miss, spatial hit, conflict");
    applyStimulus(32'h040, 2, -1, 1'b0, 32'h0);
    applyStimulus(32'h040, 0, -1, 1'b0, 32'h0);
    applyStimulus(32'h044, 0, -1, 1'b0, 32'h0);
    applyStimulus(32'h0C0, -1, -1, 1'b0, 32'h0);
    applyStimulus(32'h040, -1, -1, 1'b0, 32'h0);
    applyStimulus(32'h0C4, -1, -1, 1'b0, 32'h0);

    $display("[TB] redirect mid-fill and long arbitration stall");
    applyStimulus(32'h100, 1, -1, 1'b1, 32'h200);
    applyStimulus(32'h200, 1, -1, 1'b0, 32'h0);
    applyStimulus(32'h104, 0, -1, 1'b0, 32'h0);
    applyStimulus(32'h204, 0, -1, 1'b0, 32'h0);
    applyStimulus(32'h300, 0, 0, 1'b0, 32'h0);
    applyStimulus(32'h304, 0, -1, 1'b0, 32'h0);
    applyIdle();

    $display("[TB] random fetch stream");
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        applyIdle();
      end else begin
        a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 63) << 2);
        r = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 63) << 2);
        applyStimulus(a, -1, -1, ($urandom_range(0, 9) == 0), r);
      end
    end

    $display("[TB] reset during fill");
    applyStimulus(32'h040, 0, -1, 1'b0, 32'h0);
    imemREN  = 1'b1;
    imemaddr = 32'h500;
    iwait    = 1'b1;
    #4;
    checkOutput("rst_fill_lookup", 32'(ihit), 32'd0);
    modelMisses++;
    stepCycle();
    #4;
    checkOutput("rst_fill_iREN_pre", 32'(iREN), 32'd1);
    nRST    = 1'b0;
    imemREN = 1'b0;
    #1;
    checkOutput("rst_fill_iREN", 32'(iREN), 32'd0);
    checkOutput("rst_fill_iaddr", iaddr, 32'd0);
    checkOutput("rst_fill_ihit", 32'(ihit), 32'd0);
    for (int i = 0; i < SETS; i++) resValid[i] = 1'b0;
    modelHits   = 0;
    modelMisses = 0;
    checkStats();
    #1;
    nRST = 1'b1;
    stepCycle();
    applyStimulus(32'h040, 1, -1, 1'b0, 32'h0);
    applyStimulus(32'h044, 0, -1, 1'b0, 32'h0);
    applyIdle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
